// File: rtl/peripheral_msi_pkg_apb4.sv
// Shared types and helpers for the MSI crossbar slave-port arbiter.
package peripheral_msi_pkg_apb4;

    typedef enum logic {
        ARB_PRIO_RR = 1'b0,
        ARB_RR      = 1'b1
    } arb_mode_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    // Binary index of a one-hot vector; an all-zero vector maps to 0.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 32'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/peripheral_msi_rr_picker_apb4.sv
// Combinational picker: highest effective priority wins, ties go to the first
// requester in rotation order starting after rr_ptr.
module peripheral_msi_rr_picker_apb4 #(
    parameter int  MASTERS = 4,
    parameter int  PRIO_W  = 3,
    localparam int IW      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic [MASTERS-1:0]        req,
    input  logic [MASTERS*PRIO_W-1:0] eff_prio,
    input  logic [IW-1:0]             rr_ptr,
    output logic [MASTERS-1:0]        winner,
    output logic                      winner_valid
);
    int                idx_s;
    int                best_s;
    logic [PRIO_W-1:0] best_prio_s;

    // Strict greater-than keeps the earliest requester in rotation on equal priority.
    always_comb begin
        winner       = '0;
        winner_valid = 1'b0;
        best_s       = 0;
        best_prio_s  = '0;
        idx_s        = 0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx_s = ((int'(rr_ptr) + k) >= MASTERS) ? (int'(rr_ptr) + k - MASTERS)
                                                    : (int'(rr_ptr) + k);
            if (req[idx_s] && (!winner_valid || (eff_prio[idx_s*PRIO_W +: PRIO_W] > best_prio_s))) begin
                winner_valid = 1'b1;
                best_prio_s  = eff_prio[idx_s*PRIO_W +: PRIO_W];
                best_s       = idx_s;
            end else begin
                best_s       = best_s;
            end
        end
        if (winner_valid) begin
            winner[best_s] = 1'b1;
        end else begin
            winner = '0;
        end
    end

endmodule

// File: rtl/peripheral_msi_slave_arbiter_apb4.sv
// Per-slave-port arbiter: grant FSM with lock hold, rotation pointer,
// aging-based starvation boost and a stalled-slave timeout.
module peripheral_msi_slave_arbiter_apb4
    import peripheral_msi_pkg_apb4::*;
#(
    parameter int  MASTERS   = 4,
    parameter int  PRIO_W    = 3,
    parameter int  ARB_MODE  = 0,
    parameter int  AGE_LIMIT = 15,
    parameter int  TIMEOUT   = 64,
    localparam int IW        = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [MASTERS-1:0]        mst_req,
    input  logic [MASTERS*PRIO_W-1:0] mst_priority,
    input  logic [MASTERS-1:0]        mst_lock,
    input  logic [MASTERS-1:0]        mst_can_switch,
    input  logic                      slv_HREADY,
    output logic [MASTERS-1:0]        granted_master,
    output logic                      grant_valid,
    output logic [IW-1:0]             granted_idx,
    output logic [MASTERS-1:0]        boost_active,
    output logic                      timeout
);
    localparam int        AW      = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    localparam int        TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam arb_mode_t MODE    = (ARB_MODE != 0) ? ARB_RR : ARB_PRIO_RR;
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    arb_state_t          state_q, state_d;
    logic [MASTERS-1:0]  grant_q, grant_d;
    logic                gvalid_q, gvalid_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [MASTERS-1:0]  boost_q, boost_d;
    logic [AW-1:0]       age_q [MASTERS];
    logic [AW-1:0]       age_d [MASTERS];
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                tmo_q, tmo_d;

    logic [MASTERS*PRIO_W-1:0] eff_prio_s;
    logic [MASTERS-1:0]        winner_s;
    logic                      win_valid_s;
    logic                      arb_s;
    logic                      tmo_hit_s;
    logic                      new_grant_s;

    // Effective priority: boosted requesters jump to the maximum level.
    always_comb begin
        eff_prio_s = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (MODE == ARB_RR) begin
                eff_prio_s[i*PRIO_W +: PRIO_W] = '0;
            end else if (boost_q[i]) begin
                eff_prio_s[i*PRIO_W +: PRIO_W] = '1;
            end else begin
                eff_prio_s[i*PRIO_W +: PRIO_W] = mst_priority[i*PRIO_W +: PRIO_W];
            end
        end
    end

    peripheral_msi_rr_picker_apb4 #(
        .MASTERS (MASTERS),
        .PRIO_W  (PRIO_W)
    ) u_picker (
        .req          (mst_req),
        .eff_prio     (eff_prio_s),
        .rr_ptr       (rr_ptr_q),
        .winner       (winner_s),
        .winner_valid (win_valid_s)
    );

    // Stall watchdog: counts HREADY-low cycles while a grant is outstanding.
    always_comb begin
        tmo_hit_s = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        if (TIMEOUT == 0) begin
            tmo_cnt_d = '0;
        end else if (slv_HREADY) begin
            tmo_cnt_d = '0;
        end else if (gvalid_q) begin
            if (tmo_cnt_q == (TMO_MAX - TW'(1))) begin
                tmo_hit_s = 1'b1;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end

    // Grant FSM next state; a timeout overrides lock and re-arbitration.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gvalid_d = gvalid_q;
        rr_ptr_d = rr_ptr_q;
        arb_s    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                arb_s = 1'b1;
            end
            ARB_OWNED: begin
                if (slv_HREADY && mst_lock[idx_q]) begin
                    state_d = ARB_LOCKED;
                end else if (slv_HREADY && mst_can_switch[idx_q]) begin
                    arb_s = 1'b1;
                end else begin
                    arb_s = 1'b0;
                end
            end
            ARB_LOCKED: begin
                if (slv_HREADY && !mst_lock[idx_q]) begin
                    arb_s = 1'b1;
                end else begin
                    arb_s = 1'b0;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                grant_d  = '0;
                gvalid_d = 1'b0;
            end
        endcase
        if (arb_s && win_valid_s) begin
            state_d  = ARB_OWNED;
            grant_d  = winner_s;
            gvalid_d = 1'b1;
            rr_ptr_d = IW'(onehot_to_idx(32'(winner_s)));
        end else if (arb_s) begin
            state_d  = ARB_IDLE;
            grant_d  = '0;
            gvalid_d = 1'b0;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        if (tmo_hit_s) begin
            state_d  = ARB_IDLE;
            grant_d  = '0;
            gvalid_d = 1'b0;
            rr_ptr_d = rr_ptr_q;
        end else begin
            tmo_d = 1'b0;
        end
        tmo_d       = tmo_hit_s;
        new_grant_s = arb_s && win_valid_s && !tmo_hit_s;
        idx_d       = IW'(onehot_to_idx(32'(grant_d)));
    end

    // Aging: waiting requesters count up; dropping the request or winning clears.
    always_comb begin
        boost_d = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (AGE_LIMIT == 0 || !mst_req[i]) begin
                age_d[i] = '0;
            end else if (new_grant_s && winner_s[i]) begin
                age_d[i] = '0;
            end else if (grant_q[i] || (age_q[i] == AGE_MAX)) begin
                age_d[i] = age_q[i];
            end else begin
                age_d[i] = age_q[i] + AW'(1);
            end
            boost_d[i] = (AGE_LIMIT != 0) && (age_d[i] == AGE_MAX);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            gvalid_q  <= 1'b0;
            idx_q     <= '0;
            rr_ptr_q  <= IW'(MASTERS - 1);
            boost_q   <= '0;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            for (int i = 0; i < MASTERS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gvalid_q  <= gvalid_d;
            idx_q     <= idx_d;
            rr_ptr_q  <= rr_ptr_d;
            boost_q   <= boost_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
            for (int i = 0; i < MASTERS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign granted_master = grant_q;
    assign grant_valid    = gvalid_q;
    assign granted_idx    = idx_q;
    assign boost_active   = boost_q;
    assign timeout        = tmo_q;

endmodule

// File: tb/tb_peripheral_msi_slave_arbiter_apb4.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_peripheral_msi_slave_arbiter_apb4;
    localparam int N   = 4;
    localparam int AGE = 15;
    localparam int TMO = 64;

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic [N-1:0]   req, lock, sw;
    logic [N*3-1:0] prio;
    logic           rdy;
    logic [N-1:0]   gm, boost;
    logic           gv, tmo;
    logic [1:0]     gidx;

    int checks = 0;
    int passes = 0;

    // behavioural model: owner index (-1 = none), lock flag, last winner, waits, stall count
    int m_owner, m_rr, m_tcnt;
    bit m_locked, m_tmo;
    int m_age [N];

    always #5 HCLK = ~HCLK;

    peripheral_msi_slave_arbiter_apb4 #(
        .MASTERS(4), .PRIO_W(3), .ARB_MODE(0), .AGE_LIMIT(AGE), .TIMEOUT(TMO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .mst_req(req), .mst_priority(prio),
        .mst_lock(lock), .mst_can_switch(sw), .slv_HREADY(rdy),
        .granted_master(gm), .grant_valid(gv), .granted_idx(gidx),
        .boost_active(boost), .timeout(tmo)
    );

    function automatic int eff(input int i);
        return (m_age[i] == AGE) ? 7 : int'(prio[i*3 +: 3]);
    endfunction

    // top effective priority among requesters, then first such requester after the last winner
    function automatic int model_pick();
        int top, best, i;
        top = -1; best = -1;
        for (int m = 0; m < N; m++) if (req[m] && eff(m) > top) top = eff(m);
        for (int k = 1; k <= N; k++) begin
            i = (m_rr + k) % N;
            if (best < 0 && req[i] && eff(i) == top) best = i;
        end
        return best;
    endfunction

    function automatic logic [11:0] model_out();
        logic [N-1:0] g, b;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        b = 4'b0000;
        for (int i = 0; i < N; i++) if (m_age[i] == AGE) b[i] = 1'b1;
        return {g, (m_owner >= 0), 2'((m_owner >= 0) ? m_owner : 0), b, m_tmo};
    endfunction

    task automatic cycle();
        int nown, ntc, w;
        bit nlk, rearb, hit;
        int nage [N];
        nown = m_owner; nlk = m_locked; rearb = 1'b0; hit = 1'b0; ntc = m_tcnt; w = -1;
        if (rdy) ntc = 0;
        else if (m_owner >= 0) begin
            ntc = m_tcnt + 1;
            if (ntc == TMO) begin hit = 1'b1; ntc = 0; end
        end
        if (m_owner < 0) rearb = 1'b1;
        else if (m_locked) rearb = rdy && !lock[m_owner];
        else if (rdy && lock[m_owner]) nlk = 1'b1;
        else rearb = rdy && sw[m_owner];
        if (rearb) begin w = model_pick(); nown = w; nlk = 1'b0; end
        if (hit) begin w = -1; nown = -1; nlk = 1'b0; end
        for (int i = 0; i < N; i++) begin
            if (!req[i] || w == i) nage[i] = 0;
            else if (m_owner == i) nage[i] = m_age[i];
            else nage[i] = (m_age[i] < AGE) ? m_age[i] + 1 : AGE;
        end
        @(posedge HCLK);
        #1;
        if (!HRESETn) begin
            m_owner = -1; m_locked = 1'b0; m_rr = N - 1; m_tcnt = 0; m_tmo = 1'b0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else begin
            m_owner = nown; m_locked = nlk; m_tcnt = ntc; m_tmo = hit;
            if (w >= 0) m_rr = w;
            for (int i = 0; i < N; i++) m_age[i] = nage[i];
        end
    endtask

    task automatic do_reset();
        HRESETn = 1'b0; req = '0; lock = '0; sw = '1; rdy = 1'b1; prio = '0;
        cycle();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gm !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", gm); else passes++;
        checks++; if (gv !== 1'b0) $display("FAIL reset_valid: got %b want 0", gv); else passes++;
        checks++; if (gidx !== 2'd0) $display("FAIL reset_idx: got %0d want 0", gidx); else passes++;
        checks++; if (boost !== 4'b0000) $display("FAIL reset_boost: got %b want 0000", boost); else passes++;
        checks++; if (tmo !== 1'b0) $display("FAIL reset_timeout: got %b want 0", tmo); else passes++;
    endtask

    task automatic test_prio();
        do_reset();
        req = 4'b1010; prio = {3'd3, 3'd0, 3'd5, 3'd0};
        cycle();
        checks++; if (gm !== 4'b0010) $display("FAIL prio_grant: got %b want 0010", gm); else passes++;
        checks++; if (gidx !== 2'd1) $display("FAIL prio_idx: got %0d want 1", gidx); else passes++;
        checks++; if (gv !== 1'b1) $display("FAIL prio_valid: got %b want 1", gv); else passes++;
        req = 4'b0000;
        cycle();
        checks++; if ({gv, gm} !== 5'b0) $display("FAIL prio_release: got %b want 00000", {gv, gm}); else passes++;
    endtask

    task automatic test_tie_rr();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111; prio = {4{3'd2}};
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++; if (gm !== exp_seq[c]) $display("FAIL tie_rr_%0d: got %b want %b", c, gm, exp_seq[c]); else passes++;
        end
    endtask

    task automatic test_lock();
        bit bad;
        do_reset();
        req = 4'b0001; prio = {3'd7, 3'd0, 3'd0, 3'd0};
        cycle();
        lock = 4'b0001; req = 4'b1001; bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            rdy = (c != 2);
            cycle();
            if (gm !== 4'b0001) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL lock_hold: got %b want 0001", gm); else passes++;
        lock = 4'b0000; rdy = 1'b1;
        cycle();
        checks++; if (gm !== 4'b1000) $display("FAIL lock_release: got %b want 1000", gm); else passes++;
    endtask

    task automatic test_aging();
        int n;
        do_reset();
        req = 4'b0011; prio = {3'd0, 3'd0, 3'd0, 3'd7};
        n = 0;
        while (!boost[1] && n < 40) begin cycle(); n++; end
        checks++; if (n != 15) $display("FAIL aging_wait: got %0d cycles want 15", n); else passes++;
        checks++; if (gm !== 4'b0001) $display("FAIL aging_owner: got %b want 0001", gm); else passes++;
        cycle();
        checks++; if (gm !== 4'b0010) $display("FAIL aging_win: got %b want 0010", gm); else passes++;
        checks++; if (boost[1] !== 1'b0) $display("FAIL aging_clear: got %b want 0", boost[1]); else passes++;
    endtask

    task automatic test_timeout(input bit use_lock);
        bit bad;
        do_reset();
        req = 4'b0100; lock = use_lock ? 4'b0100 : 4'b0000;
        cycle();
        cycle();
        checks++; if (gm !== 4'b0100) $display("FAIL tmo_owner_l%0d: got %b want 0100", use_lock, gm); else passes++;
        rdy = 1'b0; bad = 1'b0;
        for (int c = 0; c < TMO - 1; c++) begin
            cycle();
            if (tmo !== 1'b0 || gv !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL tmo_early_l%0d: got tmo=%b valid=%b want 0/1", use_lock, tmo, gv); else passes++;
        cycle();
        checks++; if ({tmo, gv} !== 2'b10) $display("FAIL tmo_pulse_l%0d: got tmo,valid=%b want 10", use_lock, {tmo, gv}); else passes++;
        req = 4'b0000; lock = 4'b0000;
        cycle();
        checks++; if ({tmo, gv} !== 2'b00) $display("FAIL tmo_after_l%0d: got tmo,valid=%b want 00", use_lock, {tmo, gv}); else passes++;
        rdy = 1'b1;
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        req = 4'b0001; lock = 4'b0001;
        cycle();
        req = 4'b1001;
        cycle();
        HRESETn = 1'b0;
        cycle();
        checks++; if ({gm, gv, gidx, boost, tmo} !== 12'b0) $display("FAIL rst_lock_outs: got %b want 0", {gm, gv, gidx, boost, tmo}); else passes++;
        HRESETn = 1'b1; req = 4'b1111; lock = 4'b0000; prio = {4{3'd2}};
        cycle();
        checks++; if (gm !== 4'b0001) $display("FAIL rst_first_grant: got %b want 0001", gm); else passes++;
    endtask

    task automatic test_random();
        logic [11:0] exp_o;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            HRESETn = ($urandom_range(0, 299) != 0);
            req  = 4'($urandom);
            prio = 12'($urandom);
            for (int i = 0; i < N; i++) begin
                lock[i] = ($urandom_range(0, 7) == 0);
                sw[i]   = ($urandom_range(0, 3) != 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
            exp_o = model_out();
            checks++;
            if ({gm, gv, gidx, boost, tmo} !== exp_o)
                $display("FAIL rand_c%0d: got %b want %b", c, {gm, gv, gidx, boost, tmo}, exp_o);
            else passes++;
        end
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn = 1'b0; req = '0; lock = '0; sw = '1; rdy = 1'b1; prio = '0;
        m_owner = -1; m_locked = 1'b0; m_rr = N - 1; m_tcnt = 0; m_tmo = 1'b0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        test_reset();
        test_prio();
        test_tie_rr();
        test_lock();
        test_aging();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
